// File: rtl/fft_frame_scheduler_if.sv
// Bundle of the sample, FFT and display-side signals of fft_frame_scheduler.
// Modport "slave" is the scheduler's view. Modport "master" is the surrounding system's view:
// the codec receiver, the FFT core and the display.
interface fft_frame_scheduler_if #(
  parameter int DATA_W = 24,
  parameter int N      = 16
);
  logic [DATA_W-1:0]   sample_in;
  logic                sample_valid;
  logic                fft_start;
  logic [N*DATA_W-1:0] fft_frame;
  logic                fft_done;
  logic [N*DATA_W-1:0] fft_result;
  logic                bins_valid;
  logic                bins_ready;
  logic [N*DATA_W-1:0] bins_data;
  logic                overrun;
  logic                fft_error;

  modport slave (
    input  sample_in, sample_valid, fft_done, fft_result, bins_ready,
    output fft_start, fft_frame, bins_valid, bins_data, overrun, fft_error
  );

  modport master (
    output sample_in, sample_valid, fft_done, fft_result, bins_ready,
    input  fft_start, fft_frame, bins_valid, bins_data, overrun, fft_error
  );
endinterface

// File: rtl/fft_frame_scheduler.sv
// fft_frame_scheduler: gathers codec samples into two ping-pong N-sample frames.
// It launches one FFT per full frame, applies a completion timeout,
// and hands the captured bins to the display.
// Optional macro FFT_FRAME_STATS_EN adds the saturating frames_done / drop_count counters.
// Display handshake: bins_valid rises with bins_data stable and stays high, with data held,
// until a cycle where bins_valid && bins_ready; that cycle is the transfer.
module fft_frame_scheduler #(
  parameter int DATA_W      = 24,
  parameter int N           = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  fft_frame_scheduler_if.slave  bus,
  output logic [2:0]            o_dbg_state
`ifdef FFT_FRAME_STATS_EN
  ,
  output logic [15:0]           frames_done,
  output logic [15:0]           drop_count
`endif
);
  localparam int IDX_W = $clog2(N);
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam int FW    = N * DATA_W;

  typedef enum logic [2:0] {S_IDLE, S_START, S_RUN, S_CAPTURE, S_PRESENT} state_t;

  state_t            r_state, w_state_nxt;
  logic [FW-1:0]     r_buf [2];
  logic              r_wr_sel, r_rd_sel;
  logic [IDX_W-1:0]  r_wr_idx;
  logic [1:0]        r_full, w_full_nxt;
  logic [CNT_W-1:0]  r_tmo_cnt;
  logic [FW-1:0]     r_result, r_bins_data;
  logic              r_overrun, r_fft_error;
  logic              w_accept, w_fill, w_release, w_timeout;

  // A sample is taken only into a write buffer whose registered full flag is clear.
  assign w_accept = bus.sample_valid && !r_full[r_wr_sel];
  assign w_fill   = w_accept && (r_wr_idx == IDX_W'(N - 1));

  // Full flags: set by the ingest side on the last sample, cleared by the FSM on release.
  always_comb begin
    w_full_nxt = r_full;
    if (w_fill)    w_full_nxt[r_wr_sel] = 1'b1;
    if (w_release) w_full_nxt[r_rd_sel] = 1'b0;
  end

  // Ingest path: buffer writes, write pointer, full flags and the drop pulse.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_buf[0]  <= '0;
      r_buf[1]  <= '0;
      r_wr_sel  <= 1'b0;
      r_wr_idx  <= '0;
      r_full    <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_full    <= w_full_nxt;
      r_overrun <= bus.sample_valid && r_full[r_wr_sel];
      if (w_accept) begin
        r_buf[r_wr_sel][r_wr_idx*DATA_W +: DATA_W] <= bus.sample_in;
        if (w_fill) begin
          r_wr_idx <= '0;
          r_wr_sel <= ~r_wr_sel;
        end else begin
          r_wr_idx <= r_wr_idx + 1'b1;
        end
      end
    end
  end

  // FSM next state; fft_done in RUN has priority over the timeout terminal count.
  always_comb begin
    w_state_nxt = r_state;
    w_release   = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      S_IDLE:    if (r_full[r_rd_sel]) w_state_nxt = S_START;
      S_START:   w_state_nxt = S_RUN;
      S_RUN: begin
        if (bus.fft_done) begin
          w_state_nxt = S_CAPTURE;
        end else if (r_tmo_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_timeout   = 1'b1;
          w_release   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_CAPTURE: begin
        w_release   = 1'b1;
        w_state_nxt = S_PRESENT;
      end
      S_PRESENT: if (bus.bins_ready) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // FSM state register plus read pointer, timeout counter, result capture and sticky error.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state     <= S_IDLE;
      r_rd_sel    <= 1'b0;
      r_tmo_cnt   <= '0;
      r_result    <= '0;
      r_bins_data <= '0;
      r_fft_error <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_release) r_rd_sel <= ~r_rd_sel;
      if (r_state == S_START)     r_tmo_cnt <= '0;
      else if (r_state == S_RUN)  r_tmo_cnt <= r_tmo_cnt + 1'b1;
      if (r_state == S_RUN && bus.fft_done) r_result <= bus.fft_result;
      if (r_state == S_CAPTURE) r_bins_data <= r_result;
      if (w_timeout) r_fft_error <= 1'b1;
    end
  end

  assign bus.fft_start  = (r_state == S_START);
  assign bus.fft_frame  = r_buf[r_rd_sel];
  assign bus.bins_valid = (r_state == S_PRESENT);
  assign bus.bins_data  = r_bins_data;
  assign bus.overrun    = r_overrun;
  assign bus.fft_error  = r_fft_error;
  assign o_dbg_state    = r_state;

`ifdef FFT_FRAME_STATS_EN
  logic [15:0] r_frames_done, r_drop_count;

  // Saturating counts of captured frames and dropped samples.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_frames_done <= '0;
      r_drop_count  <= '0;
    end else begin
      if (r_state == S_CAPTURE && r_frames_done != 16'hFFFF) r_frames_done <= r_frames_done + 16'd1;
      if (r_overrun && r_drop_count != 16'hFFFF) r_drop_count <= r_drop_count + 16'd1;
    end
  end

  assign frames_done = r_frames_done;
  assign drop_count  = r_drop_count;
`endif
endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Bench for fft_frame_scheduler: randomized samples and an FFT responder.
// The reference model works in frames and buffer occupancy, not in FSM terms.
// Expected frames, bins and drop cycles are queued and checked by a negedge monitor.
module tb_fft_frame_scheduler;
  localparam int DATA_W = 24;
  localparam int N = 16;
  localparam int TIMEOUT_CYC = 64;
  localparam int FW = N * DATA_W;
  localparam int NEVER = 32'h7fffffff;

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  logic [2:0] dbg_state;
`ifdef FFT_FRAME_STATS_EN
  logic [15:0] frames_done, drop_count;
`endif

  fft_frame_scheduler_if #(.DATA_W(DATA_W), .N(N)) bus();

  fft_frame_scheduler #(.DATA_W(DATA_W), .N(N), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus), .o_dbg_state(dbg_state)
`ifdef FFT_FRAME_STATS_EN
    , .frames_done(frames_done), .drop_count(drop_count)
`endif
  );

  // ---------------- clock / cycle counter ----------------
  always #5 Clk = ~Clk;
  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- counters and check helpers ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_msg(input string nm, input int act, input int exp);
    checks++;
    failures++;
    $display("FAIL %s act=%0d exp=%0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // ---------------- reference model state ----------------
  logic [FW-1:0] exp_frame_q[$];
  logic [FW-1:0] exp_bins_q[$];
  int rel_q[$];
  int ovr_q[$];
  int occ = 0;
  int wr_cnt = 0;
  logic [FW-1:0] part = '0;
  int n_drop = 0;
  int n_capt = 0;
  int err_cyc = NEVER;
  int done_cyc = -1;
  int resp_end_cyc = -1;
  int resp_mode = 0;
  int resp_d = 0;
  logic [FW-1:0] resp_res = '0;
  logic [FW-1:0] cur_frame = '0;
  logic [FW-1:0] cur_bins = '0;
  int last_full_cyc = -1;
  int last_start_cyc = -1;
  int n_starts = 0;
  int n_valid_cyc = 0;
  int n_ovr_seen = 0;
  bit prev_valid = 0;
  bit rdy_rand = 0;

  // ---------------- driver ----------------
  // One call = one cycle. A sample is lost only when both frame buffers hold unconsumed frames.
  task automatic drive_cycle(input bit vld, input logic [DATA_W-1:0] v);
    @(negedge Clk);
    while (rel_q.size() > 0 && rel_q[0] <= cyc) begin
      void'(rel_q.pop_front());
      occ--;
    end
    if (rdy_rand) bus.bins_ready = ($urandom_range(0, 3) != 0);
    bus.sample_valid = vld;
    bus.sample_in = v;
    if (vld) begin
      if (occ == 2) begin
        ovr_q.push_back(cyc + 1);
        n_drop++;
      end else begin
        part[wr_cnt*DATA_W +: DATA_W] = v;
        wr_cnt++;
        if (wr_cnt == N) begin
          exp_frame_q.push_back(part);
          occ++;
          wr_cnt = 0;
          last_full_cyc = cyc;
        end
      end
    end
  endtask

  task automatic feed_random(input int n);
    for (int i = 0; i < n; i++) drive_cycle(1'b1, DATA_W'($urandom));
  endtask

  task automatic model_reset();
    exp_frame_q.delete();
    ovr_q.delete();
    occ = 0;
    wr_cnt = 0;
    part = '0;
    n_drop = 0;
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while (k < 2000 && (exp_frame_q.size() != 0 || exp_bins_q.size() != 0 ||
           cyc <= resp_end_cyc || bus.bins_valid || dbg_state != 3'd0)) begin
      drive_cycle(1'b0, '0);
      k++;
    end
    if (k >= 2000) fail_msg({"drain_timeout_", nm}, exp_frame_q.size() + exp_bins_q.size(), 0);
    drive_cycle(1'b0, '0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_fft_start"}, FW'(bus.fft_start), '0);
    chk({tag, "_fft_frame"}, bus.fft_frame, '0);
    chk({tag, "_bins_valid"}, FW'(bus.bins_valid), '0);
    chk({tag, "_bins_data"}, bus.bins_data, '0);
    chk({tag, "_overrun"}, FW'(bus.overrun), '0);
    chk({tag, "_fft_error"}, FW'(bus.fft_error), '0);
    chk({tag, "_state"}, FW'(dbg_state), '0);
  endtask

  // ---------------- FFT responder ----------------
  // Models the FFT core: on each fft_start it picks a latency and pre-computes how the run ends.
  // A done within TIMEOUT_CYC run cycles is a capture; the buffer frees two cycles after done.
  // Otherwise error and release follow TIMEOUT_CYC+1 cycles after start.
  always @(negedge Clk) begin
    if (!Reset_n) begin
      bus.fft_done = 1'b0;
      bus.fft_result = '0;
      done_cyc = -1;
      resp_end_cyc = -1;
      err_cyc = NEVER;
      n_capt = 0;
      exp_bins_q.delete();
      rel_q.delete();
    end else begin
      if (bus.fft_start) begin
        case (resp_mode)
          0: resp_d = 5;
          1: resp_d = NEVER;
          2: resp_d = TIMEOUT_CYC;
          3: resp_d = $urandom_range(1, TIMEOUT_CYC);
          default: resp_d = $urandom_range(1, TIMEOUT_CYC + 16);
        endcase
        for (int k = 0; k < N; k++)
          resp_res[k*DATA_W +: DATA_W] = (resp_mode == 0) ? DATA_W'(100 + k) : DATA_W'($urandom);
        if (resp_d <= TIMEOUT_CYC) begin
          done_cyc = cyc + resp_d;
          rel_q.push_back(cyc + resp_d + 2);
          exp_bins_q.push_back(resp_res);
          n_capt++;
          resp_end_cyc = cyc + resp_d + 2;
        end else begin
          done_cyc = -1;
          rel_q.push_back(cyc + TIMEOUT_CYC + 1);
          if (err_cyc > cyc + TIMEOUT_CYC + 1) err_cyc = cyc + TIMEOUT_CYC + 1;
          resp_end_cyc = cyc + TIMEOUT_CYC + 1;
        end
      end
      if (cyc == done_cyc) chk("frame_stable_at_done", bus.fft_frame, cur_frame);
      bus.fft_done = (cyc == done_cyc);
      bus.fft_result = (cyc == done_cyc) ? resp_res : ~resp_res;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    if (!Reset_n) begin
      prev_valid = 0;
    end else begin
      if (bus.fft_start) begin
        n_starts++;
        last_start_cyc = cyc;
        if (exp_frame_q.size() == 0) fail_msg("start_without_frame", 1, 0);
        else begin
          cur_frame = exp_frame_q.pop_front();
          chk("fft_frame", bus.fft_frame, cur_frame);
        end
      end
      if (bus.bins_valid) begin
        n_valid_cyc++;
        if (!prev_valid) begin
          if (exp_bins_q.size() == 0) fail_msg("bins_without_capture", 1, 0);
          else cur_bins = exp_bins_q.pop_front();
        end
        chk("bins_data", bus.bins_data, cur_bins);
      end
      prev_valid = bus.bins_valid;
      if (bus.overrun) begin
        n_ovr_seen++;
        if (ovr_q.size() == 0) fail_msg("overrun_unexpected", 1, 0);
        else chk("overrun_cycle", FW'(cyc), FW'(ovr_q.pop_front()));
      end else if (ovr_q.size() > 0 && ovr_q[0] <= cyc) begin
        fail_msg("overrun_missing", 0, 1);
        void'(ovr_q.pop_front());
      end
      chk("fft_error", FW'(bus.fft_error), FW'(cyc >= err_cyc));
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  logic [FW-1:0] exp100;

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_in = '0;
    bus.bins_ready = 1'b0;
    for (int k = 0; k < N; k++) exp100[k*DATA_W +: DATA_W] = DATA_W'(100 + k);

    // reset state
    #1 Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    check_zero_outputs("reset");
    model_reset();
    Reset_n = 1'b1;

    // frame 1..16, FFT done after 5 cycles with 100+k, display always ready
    resp_mode = 0;
    bus.bins_ready = 1'b1;
    for (int k = 1; k <= N; k++) drive_cycle(1'b1, DATA_W'(k));
    repeat (4) drive_cycle(1'b0, '0);
    chk("start_latency", FW'(last_start_cyc), FW'(last_full_cyc + 2));
    chk("start_count", FW'(n_starts), FW'(1));
    drain("basic");
    chk("bins_valid_cycles", FW'(n_valid_cyc), FW'(1));
    chk("bins_hold_after_handshake", bus.bins_data, exp100);

    // display stalled while 64 samples arrive back-to-back
    bus.bins_ready = 1'b0;
    feed_random(64);
    repeat (3) drive_cycle(1'b0, '0);
    chk("overrun_pulses_stalled", FW'(n_ovr_seen), FW'(16));
`ifdef FFT_FRAME_STATS_EN
    chk("drop_count_stalled", FW'(drop_count), FW'(16));
`endif
    bus.bins_ready = 1'b1;
    drain("stalled");

    // done coincides with the timeout terminal count
    resp_mode = 2;
    feed_random(N);
    drain("tie");
    chk("error_after_tie", FW'(bus.fft_error), '0);

    // FFT never finishes
    resp_mode = 1;
    feed_random(N);
    drain("timeout");
    chk("error_after_timeout", FW'(bus.fft_error), FW'(1));
    chk("idle_after_timeout", FW'(dbg_state), '0);

    // next frame runs normally
    resp_mode = 3;
    feed_random(N);
    drain("restart");

    // async reset mid-RUN with a 7-sample partial frame
    resp_mode = 1;
    feed_random(N);
    repeat (3) drive_cycle(1'b0, '0);
    feed_random(7);
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1 check_zero_outputs("async_reset");
    bus.sample_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    resp_mode = 3;
    for (int k = 0; k < N; k++) drive_cycle(1'b1, DATA_W'(1000 + k));
    drain("post_reset");

    // random traffic, random display readiness, occasional timeouts
    rdy_rand = 1;
    resp_mode = 4;
    for (int i = 0; i < 600; i++) drive_cycle($urandom_range(0, 3) != 0, DATA_W'($urandom));
    rdy_rand = 0;
    bus.bins_ready = 1'b1;
    drain("random");

    chk("overrun_leftover", FW'(ovr_q.size()), '0);
`ifdef FFT_FRAME_STATS_EN
    chk("frames_done", FW'(frames_done), FW'(n_capt));
    chk("drop_count", FW'(drop_count), FW'(n_drop));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
